vector_list_player: RTL and testbench
=====================================

# vector_list_player

Display-list sequencer feeding the line-draw `control` block. It holds a parametrised list of vector commands (jump/draw to absolute x,y, end-of-frame, nop) written by the host. It replays the list to the line drawer through a clean synchronous ready/strobe handshake, once or looping per frame. It replaces the free-running test-pattern generator at the top level and retires the negedge-on-ready clocking.

## Interface
- `COORD_W`, 12, coordinate width (x and y)
- `DEPTH`, 64, list entries; power of two, ≥ 2
- `ADDR_W`, $clog2(DEPTH), list address width
- `FCNT_W`, 16, frame counter width
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  write list entry at `wr_addr`
- `wr_addr`  in  ADDR_W  list write address
- `wr_cmd`  in  2  00 JUMP, 01 DRAW, 10 END, 11 NOP
- `wr_x`, `wr_y`  in  COORD_W each  target coordinates
- `start`  in  1  begin playback from entry 0 (sampled in IDLE only)
- `loop_en`  in  1  at END: 1 = restart at entry 0, 0 = stop
- `stop`  in  1  request stop after current vector completes
- `ready`  in  1  line drawer idle / can accept
- `x`, `y`  out  COORD_W each  target coordinates to drawer
- `draw`, `jump`  out  1 each  one-cycle command strobes to drawer
- `busy`  out  1  high in any state other than IDLE
- `frame_done`  out  1  one-cycle pulse per END processed
- `frame_count`  out  FCNT_W  frames completed, wraps modulo 2^FCNT_W

## Operation
- List RAM: DEPTH × (2+2·COORD_W), one synchronous write port, one synchronous read port (1-cycle latency). Read-before-write on same-address collision. Writes are allowed at any time, including during playback.
- Program counter `pc` (ADDR_W bits) is internal.
- FSM states: IDLE, READ, DECODE, ISSUE, STROBE, HOLD, WAIT.
- IDLE: `start`=1 → `pc`←0, go to READ.
- READ: RAM address = `pc` → DECODE.
- DECODE, by cmd:
  - JUMP/DRAW: load `x`,`y` from entry; latch type → ISSUE.
  - NOP: advance.
  - END: pulse `frame_done`, `frame_count`+1; then `pc`←0 → READ if `loop_en`=1 and no stop pending, else IDLE.
- ISSUE: hold until `ready`=1 → STROBE.
- STROBE: exactly one of `draw`/`jump` high for one cycle → HOLD.
- HOLD: one cycle; `ready` ignored, because the drawer drops `ready` the cycle after accepting → WAIT.
- WAIT: when `ready`=1, advance.
- Advance: if stop pending → IDLE; else `pc`+1 → READ. When `pc`=DEPTH-1, advancing is treated as END: pulse `frame_done`, count the frame, wrap `pc` to 0, and apply the END rules.
- `stop`: sets a sticky stop-pending flag while busy. It is cleared on entry to IDLE. `stop` in IDLE is ignored.
- `start` while busy: ignored. `start` and `stop` in the same IDLE cycle: start wins; the stop flag is not set.
- `x`/`y` change only in DECODE and are stable from then through WAIT.

## Timing
- Reset (async assert, released synchronously by clk): FSM=IDLE, `pc`=0, `x`=`y`=0, `draw`=`jump`=0, `busy`=0, `frame_done`=0, `frame_count`=0, stop flag=0. List RAM contents are not reset.
- Reset mid-playback: all outputs go to their reset values immediately; no strobe completes.
- `start` sampled at edge k with `ready`=1: READ k+1, DECODE k+2, ISSUE k+3, strobe high in cycle k+4.
- Per-vector minimum period with instant drawer (`ready` low only in HOLD): 6 cycles strobe-to-strobe (STROBE, HOLD, WAIT, READ, DECODE, ISSUE).
- NOP costs 2 cycles (READ, DECODE).
- END plus loop costs 2 cycles before the next READ. `frame_done` is high in the DECODE cycle that processes END.
- All outputs are registered or Moore-decoded from FSM state; there are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle: assert `reset` mid-stream while `draw` is high → `draw`=0, `busy`=0, `frame_count`=0 in the same cycle. Hold `ready`=1 → no strobes.
- Single frame: list = JUMP(10,20), DRAW(100,20), END, `loop_en`=0; drawer model drops `ready` for 5 cycles per accepted command → exactly one `jump` with x=10,y=20, then one `draw` with x=100,y=20, one `frame_done`, `frame_count`=1, `busy` falls. First strobe occurs 4 cycles after `start`.
- Looping + stop: same list with `loop_en`=1 → `frame_count` reaches 3. Assert `stop` during the DRAW of frame 4 → that DRAW completes, no further strobe, IDLE, `frame_count`=3.
- NOP and full-depth wrap: DEPTH=4, list = NOP, DRAW(1,1), DRAW(2,2), DRAW(3,3), no END → 3 strobes, then implicit END: `frame_done` pulses and `pc` wraps to 0.
- Stall: hold `ready`=0 for 50 cycles in ISSUE → no strobe and `x`/`y` stable; release → strobe on the following cycle.
- Live write + counter wrap: during playback, rewrite entry 1 before it is fetched → new coordinates are issued. With FCNT_W=2, 4 frames → `frame_count` wraps from 3 to 0.

Source files
------------

// File: rtl/vector_list_player.sv
// vector_list_player: display-list sequencer for the line-draw block.
// Holds a host-written list of JUMP/DRAW/END/NOP commands and replays it to
// the drawer through a synchronous ready/strobe handshake, once or looping.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_cmd/wr_x/wr_y   host list write port (any time)
//   start, loop_en, stop       playback control
//   ready                      drawer can accept a command
//   x, y, draw, jump           coordinates and one-cycle command strobes
//   busy                       high whenever not IDLE
//   frame_done, frame_count    per-frame pulse and wrapping frame counter
module vector_list_player #(
    parameter int unsigned COORD_W = 12,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned FCNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [1:0]         wr_cmd,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic               start,
    input  logic               loop_en,
    input  logic               stop,
    input  logic               ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               draw,
    output logic               jump,
    output logic               busy,
    output logic               frame_done,
    output logic [FCNT_W-1:0]  frame_count
);

    localparam int unsigned ENT_W = 2 + 2 * COORD_W;

    localparam logic [1:0] CMD_JUMP = 2'b00;
    localparam logic [1:0] CMD_DRAW = 2'b01;
    localparam logic [1:0] CMD_END  = 2'b10;
    localparam logic [1:0] CMD_NOP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DECODE,
        S_ISSUE,
        S_STROBE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic               stop_pend;
    logic               is_draw;
    logic               wrap_pulse;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   rd_data;

    logic [1:0]         rd_cmd;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               last_pc;
    logic               end_hit;

    // List RAM: non-blocking read and write give read-before-write on collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_cmd, wr_x, wr_y};
        end
        rd_data <= mem[pc];
    end

    assign rd_cmd  = rd_data[ENT_W-1 -: 2];
    assign rd_x    = rd_data[2*COORD_W-1 -: COORD_W];
    assign rd_y    = rd_data[COORD_W-1:0];
    assign last_pc = (pc == ADDR_W'(DEPTH - 1));

    // A NOP in the last slot advances past the end, so it closes the frame too.
    assign end_hit = (rd_cmd == CMD_END) || ((rd_cmd == CMD_NOP) && last_pc);

    // Explicit END pulses during its DECODE cycle; a wrap out of WAIT pulses
    // from a register one cycle later. Both sources are registered state.
    assign frame_done = ((state == S_DECODE) && end_hit) || wrap_pulse;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            x           <= '0;
            y           <= '0;
            draw        <= 1'b0;
            jump        <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            stop_pend   <= 1'b0;
            is_draw     <= 1'b0;
            wrap_pulse  <= 1'b0;
        end else begin
            draw       <= 1'b0;
            jump       <= 1'b0;
            wrap_pulse <= 1'b0;

            if ((state != S_IDLE) && stop) begin
                stop_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= S_READ;
                    end
                end

                S_READ: begin
                    state <= S_DECODE;
                end

                S_DECODE: begin
                    if ((rd_cmd == CMD_JUMP) || (rd_cmd == CMD_DRAW)) begin
                        x       <= rd_x;
                        y       <= rd_y;
                        is_draw <= (rd_cmd == CMD_DRAW);
                        state   <= S_ISSUE;
                    end else if (end_hit) begin
                        frame_count <= frame_count + FCNT_W'(1);
                        pc          <= '0;
                        if (loop_en && !stop_pend) begin
                            state <= S_READ;
                        end else begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end
                    end else if (stop_pend) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                    end else begin
                        pc    <= pc + ADDR_W'(1);
                        state <= S_READ;
                    end
                end

                S_ISSUE: begin
                    if (ready) begin
                        draw  <= is_draw;
                        jump  <= !is_draw;
                        state <= S_STROBE;
                    end
                end

                S_STROBE: begin
                    state <= S_HOLD;
                end

                // Drawer drops ready only the cycle after accepting; skip that cycle.
                S_HOLD: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (ready) begin
                        if (last_pc) begin
                            wrap_pulse  <= 1'b1;
                            frame_count <= frame_count + FCNT_W'(1);
                            pc          <= '0;
                            if (loop_en && !stop_pend) begin
                                state <= S_READ;
                            end else begin
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                                stop_pend <= 1'b0;
                            end
                        end else if (stop_pend) begin
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            pc    <= pc + ADDR_W'(1);
                            state <= S_READ;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_list_player.sv
// tb_vector_list_player: directed bench for vector_list_player (DEPTH=4,
// FCNT_W=2) with a drawer model that drops ready for 5 cycles per command.
module tb_vector_list_player;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned FCNT_W  = 2;

    localparam int C_JUMP = 0;
    localparam int C_DRAW = 1;
    localparam int C_END  = 2;
    localparam int C_NOP  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [1:0]         wr_cmd;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic               start;
    logic               loop_en;
    logic               stop;
    logic               ready;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               draw;
    logic               jump;
    logic               busy;
    logic               frame_done;
    logic [FCNT_W-1:0]  frame_count;

    vector_list_player #(
        .COORD_W(COORD_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .FCNT_W (FCNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_cmd     (wr_cmd),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .start      (start),
        .loop_en    (loop_en),
        .stop       (stop),
        .ready      (ready),
        .x          (x),
        .y          (y),
        .draw       (draw),
        .jump       (jump),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Drawer model: busy for 5 cycles after seeing a strobe; stall forces ready low.
    int   dr_cnt   = 0;
    logic dr_ready = 1'b1;
    logic stall    = 1'b0;
    assign ready = dr_ready & ~stall;

    always @(negedge clk) begin
        if (draw || jump) dr_cnt = 5;
        else if (dr_cnt > 0) dr_cnt = dr_cnt - 1;
        dr_ready = (dr_cnt == 0);
    end

    // Strobe and frame_done log.
    int lg_kind [32];
    int lg_x    [32];
    int lg_y    [32];
    int lg_t    [32];
    int log_n   = 0;
    int fd_n    = 0;
    int fd_cyc  = 0;
    int both_hi = 0;

    always @(negedge clk) begin
        if (draw && jump) both_hi = both_hi + 1;
        if ((draw || jump) && log_n < 32) begin
            lg_kind[log_n] = draw ? 1 : 0;
            lg_x[log_n]    = int'(x);
            lg_y[log_n]    = int'(y);
            lg_t[log_n]    = cyc;
            log_n          = log_n + 1;
        end
        if (frame_done) begin
            fd_n   = fd_n + 1;
            fd_cyc = cyc;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input int c, input int xv, input int yv);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_cmd  = 2'(c);
        wr_x    = COORD_W'(xv);
        wr_y    = COORD_W'(yv);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_basic();
        wr(0, C_JUMP, 10, 20);
        wr(1, C_DRAW, 100, 20);
        wr(2, C_END, 0, 0);
        wr(3, C_NOP, 0, 0);
    endtask

    task automatic clear_log();
        @(negedge clk);
        log_n = 0;
        fd_n  = 0;
    endtask

    // t0 is the cycle in which start is high.
    task automatic kick(input logic lp, output int t0);
        @(negedge clk);
        loop_en = lp;
        start   = 1'b1;
        t0      = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int k = 0; k < budget && busy; k++) @(negedge clk);
        check(tag, int'(busy), 0);
    endtask

    task automatic wait_strobes(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && log_n < n; k++) @(negedge clk);
        check(tag, int'(log_n >= n), 1);
    endtask

    int t0;
    int rel;
    int n_at;
    int unstable;
    int found;

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_cmd  = '0;
        wr_x    = '0;
        wr_y    = '0;
        start   = 1'b0;
        loop_en = 1'b0;
        stop    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_draw", int'(draw), 0);
        check("rst_jump", int'(jump), 0);
        check("rst_fcnt", int'(frame_count), 0);
        check("rst_fd",   int'(frame_done), 0);
        check("rst_x",    int'(x), 0);
        reset = 1'b0;

        // Idle with ready high: nothing happens
        clear_log();
        repeat (10) @(negedge clk);
        check("idle_nostrobe", log_n, 0);
        check("idle_busy", int'(busy), 0);

        // Single frame: JUMP(10,20), DRAW(100,20), END
        load_basic();
        clear_log();
        kick(1'b0, t0);
        wait_idle("single_idle", 200);
        check("single_nstrobe", log_n, 2);
        check("single_k0",  lg_kind[0], 0);
        check("single_x0",  lg_x[0], 10);
        check("single_y0",  lg_y[0], 20);
        check("single_t0",  lg_t[0] - t0, 4);
        check("single_k1",  lg_kind[1], 1);
        check("single_x1",  lg_x[1], 100);
        check("single_y1",  lg_y[1], 20);
        check("single_t1",  lg_t[1] - t0, 13);
        check("single_fd",  fd_n, 1);
        check("single_fdt", fd_cyc - t0, 20);
        check("single_fcnt", int'(frame_count), 1);

        // Reset mid-stream while draw is high
        kick(1'b1, t0);
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (draw) found = 1;
        end
        check("rstmid_seen_draw", found, 1);
        reset = 1'b1;
        #1;
        check("rstmid_draw", int'(draw), 0);
        check("rstmid_jump", int'(jump), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_fcnt", int'(frame_count), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        repeat (10) @(negedge clk);
        check("rstmid_nostrobe", log_n, 0);

        // Looping, stop during the DRAW of frame 4
        clear_log();
        kick(1'b1, t0);
        found = 0;
        for (int k = 0; k < 1000 && found == 0; k++) begin
            @(negedge clk);
            if (draw && frame_count == 2'd3) found = 1;
        end
        check("loop_reach3", found, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_at = log_n;
        wait_idle("loop_idle", 200);
        repeat (10) @(negedge clk);
        check("loop_nomore", log_n, n_at);
        check("loop_nstrobe", log_n, 8);
        check("loop_fcnt", int'(frame_count), 3);
        check("loop_fd", fd_n, 3);

        // Live rewrite of entry 1 and counter wrap 3 -> 0
        clear_log();
        kick(1'b0, t0);
        wait_strobes("live_first", 1, 100);
        wr(1, C_DRAW, 555, 666);
        wait_idle("live_idle", 200);
        check("live_nstrobe", log_n, 2);
        check("live_k1", lg_kind[1], 1);
        check("live_x1", lg_x[1], 555);
        check("live_y1", lg_y[1], 666);
        check("live_fcnt_wrap", int'(frame_count), 0);
        check("live_fd", fd_n, 1);

        // Stall in ISSUE for 50 cycles
        load_basic();
        clear_log();
        stall = 1'b1;
        kick(1'b0, t0);
        repeat (2) @(negedge clk);
        unstable = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (x != 12'd10 || y != 12'd20) unstable = unstable + 1;
        end
        check("stall_nostrobe", log_n, 0);
        check("stall_xy_stable", unstable, 0);
        check("stall_busy", int'(busy), 1);
        stall = 1'b0;
        rel   = cyc;
        wait_strobes("stall_release", 1, 20);
        check("stall_rel_t", lg_t[0] - rel, 1);
        wait_idle("stall_idle", 200);
        check("stall_fcnt", int'(frame_count), 1);

        // NOP + full-depth wrap with no END
        wr(0, C_NOP, 0, 0);
        wr(1, C_DRAW, 1, 1);
        wr(2, C_DRAW, 2, 2);
        wr(3, C_DRAW, 3, 3);
        clear_log();
        kick(1'b1, t0);
        wait_strobes("wrap_four", 4, 300);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("wrap_idle", 200);
        check("wrap_nstrobe", log_n, 4);
        check("wrap_x0", lg_x[0], 1);
        check("wrap_x1", lg_x[1], 2);
        check("wrap_y2", lg_y[2], 3);
        check("wrap_k3", lg_kind[3], 1);
        check("wrap_x3_pc0", lg_x[3], 1);
        check("wrap_fd", fd_n, 1);
        check("wrap_fcnt", int'(frame_count), 2);

        check("one_strobe_only", both_hi, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
